// File: rtl/axi_slave_ram.sv
// AXI4-Lite slave word memory: single-beat reads with programmable wait states,
// independent AW/W capture, SLVERR for addresses outside the configured window.
module axi_slave_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o
);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- read path ----------------
  rd_state_e        rd_state;
  logic [3:0]       rd_cnt;
  logic [31:0]      ar_addr_q;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_off;
  logic             rd_in;
  logic [IDX_W-1:0] rd_idx;
  logic             ar_hs;
  logic             rd_sample;

  // With zero wait states the word is sampled on the AR handshake edge itself,
  // so the live bus address is used instead of the latched copy.
  assign rd_addr = (rd_state == R_IDLE) ? araddr_i : ar_addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_in   = (rd_addr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
  assign rd_idx  = rd_off[IDX_W+1:2];
  assign ar_hs   = arvalid_i && arready_o;

  always_comb begin
    rd_sample = 1'b0;
    if (rd_state == R_IDLE && ar_hs && RD_LATENCY == 0) rd_sample = 1'b1;
    if (rd_state == R_WAIT && rd_cnt == 4'd1)            rd_sample = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state  <= R_IDLE;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= OKAY;
      rd_cnt    <= '0;
      ar_addr_q <= '0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          arready_o <= 1'b1;
          if (ar_hs) begin
            arready_o <= 1'b0;
            ar_addr_q <= araddr_i;
            rd_cnt    <= 4'(RD_LATENCY);
            rd_state  <= R_WAIT;
          end
        end
        R_WAIT: begin
          arready_o <= 1'b0;
          rd_cnt    <= rd_cnt - 4'd1;
        end
        R_RESP: begin
          if (rready_i) begin
            rvalid_o  <= 1'b0;
            arready_o <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
      // A write committing on this same edge lands after this read, so the
      // read sees the old word.
      if (rd_sample) begin
        rd_state <= R_RESP;
        rvalid_o <= 1'b1;
        rdata_o  <= rd_in ? mem[rd_idx] : 32'h0;
        rresp_o  <= rd_in ? OKAY : SLVERR;
      end
    end
  end

  // ---------------- write path ----------------
  logic             aw_held, w_held;
  logic [31:0]      aw_addr_q, w_data_q;
  logic             aw_hs, w_hs;
  logic             wr_commit;
  logic [31:0]      wr_addr, wr_data, wr_off;
  logic             wr_in;
  logic [IDX_W-1:0] wr_idx;

  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  // Commit on the edge that completes the pair, taking whichever half is
  // still on the bus directly.
  assign wr_commit = !bvalid_o && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr   = aw_held ? aw_addr_q : awaddr_i;
  assign wr_data   = w_held  ? w_data_q  : wdata_i;
  assign wr_off    = wr_addr - BASE_ADDR;
  assign wr_in     = (wr_addr >= BASE_ADDR) && ({1'b0, wr_off} < SPAN);
  assign wr_idx    = wr_off[IDX_W+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awready_o <= 1'b0;
      wready_o  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bvalid_o  <= 1'b0;
      bresp_o   <= OKAY;
    end else if (bvalid_o) begin
      if (bready_i) begin
        bvalid_o  <= 1'b0;
        aw_held   <= 1'b0;
        w_held    <= 1'b0;
        awready_o <= 1'b1;
        wready_o  <= 1'b1;
      end
    end else if (wr_commit) begin
      bvalid_o  <= 1'b1;
      bresp_o   <= wr_in ? OKAY : SLVERR;
      aw_held   <= 1'b1;
      w_held    <= 1'b1;
      awready_o <= 1'b0;
      wready_o  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr_i;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata_i;
      end
      awready_o <= !(aw_held || aw_hs);
      wready_o  <= !(w_held || w_hs);
    end
  end

  // Storage has no reset; out-of-window writes are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_commit && wr_in) mem[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram; expected R/B responses are queued by the
// stimulus and popped by an independent monitor on each handshake.
module tb_axi_slave_ram;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned RDL   = 1;
  localparam logic [1:0]  OK    = 2'b00;
  localparam logic [1:0]  SERR  = 2'b10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        arvalid_i, arready_o, rvalid_o, rready_i;
  logic [31:0] araddr_i, rdata_o;
  logic [1:0]  rresp_o;
  logic        awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
  logic [31:0] awaddr_i, wdata_i;
  logic [1:0]  bresp_o;

  int n_chk = 0;
  int n_err = 0;
  logic [33:0] exp_rd[$];
  logic [1:0]  exp_wr[$];
  logic [33:0] mon_r;
  logic [1:0]  mon_b;

  axi_slave_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RDL)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: handshake timed out at %0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per R or B handshake.
  always @(negedge clk) begin
    if (!rst_i && rvalid_o && rready_i) begin
      if (exp_rd.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL r_stray: got rdata=%h rresp=%b, expected no response", rdata_o, rresp_o);
      end else begin
        mon_r = exp_rd.pop_front();
        chk("r_data", rdata_o, mon_r[31:0]);
        chk("r_resp", 32'(rresp_o), 32'(mon_r[33:32]));
      end
    end
    if (!rst_i && bvalid_o && bready_i) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL b_stray: got bresp=%b, expected no response", bresp_o);
      end else begin
        mon_b = exp_wr.pop_front();
        chk("b_resp", 32'(bresp_o), 32'(mon_b));
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rsp);
    bit aw_done, w_done, a_now, w_now;
    aw_done = 0; w_done = 0;
    exp_wr.push_back(rsp);
    awaddr_i = a; wdata_i = d; awvalid_i = 1; wvalid_i = 1;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      a_now = awvalid_i && awready_o;
      w_now = wvalid_i && wready_o;
      step();
      if (a_now) begin awvalid_i = 0; aw_done = 1; end
      if (w_now) begin wvalid_i = 0; w_done = 1; end
    end
    awvalid_i = 0; wvalid_i = 0;
    if (!(aw_done && w_done)) tmo("aw_w_timeout");
    chk("b_latency", 32'(bvalid_o), 32'd1);
    if (bready_i) step();
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rsp);
    bit hs;
    hs = 0;
    exp_rd.push_back({rsp, d});
    araddr_i = a; arvalid_i = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = arready_o;
      step();
    end
    arvalid_i = 0;
    if (!hs) tmo("ar_timeout");
    for (int k = 0; k < RDL; k++) begin
      chk("r_early", 32'(rvalid_o), 32'd0);
      step();
    end
    chk("r_latency", 32'(rvalid_o), 32'd1);
    if (rready_i) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; arvalid_i = 0; araddr_i = 0; rready_i = 1;
    awvalid_i = 0; awaddr_i = 0; wvalid_i = 0; wdata_i = 0; bready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {29'd0, arready_o, awready_o, wready_o}, 32'd0);
    chk("rst_valid", {30'd0, rvalid_o, bvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_resp", {28'd0, rresp_o, bresp_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 0;
    step();
    chk("ready_rise", {29'd0, arready_o, awready_o, wready_o}, 32'd7);

    // basic write/read, address low bits ignored
    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, OK);
    axi_read(BASE + 32'h10, 32'hDEAD_BEEF, OK);
    axi_read(BASE + 32'h13, 32'hDEAD_BEEF, OK);

    // W leads AW by 3 cycles
    exp_wr.push_back(OK);
    wdata_i = 32'hA5A5_0001; wvalid_i = 1;
    step();
    wvalid_i = 0;
    for (int k = 0; k < 3; k++) begin
      chk("wfirst_wready", 32'(wready_o), 32'd0);
      chk("wfirst_awready", 32'(awready_o), 32'd1);
      chk("wfirst_nob", 32'(bvalid_o), 32'd0);
      if (k < 2) step();
    end
    awaddr_i = BASE; awvalid_i = 1;
    step();
    awvalid_i = 0;
    chk("wfirst_b_lat", 32'(bvalid_o), 32'd1);
    step();
    axi_read(BASE, 32'hA5A5_0001, OK);

    // out-of-window accesses; 0x40 aliases word 0 in the index bits
    axi_read(BASE + DEPTH * 4, 32'h0, SERR);
    axi_read(BASE - 32'h4, 32'h0, SERR);
    axi_write(BASE + DEPTH * 4, 32'hBAD0_BAD0, SERR);
    axi_read(BASE, 32'hA5A5_0001, OK);

    // R back-pressure
    rready_i = 0;
    axi_read(BASE + 32'h10, 32'hDEAD_BEEF, OK);
    for (int k = 0; k < 5; k++) begin
      chk("rhold_valid", 32'(rvalid_o), 32'd1);
      chk("rhold_data", rdata_o, 32'hDEAD_BEEF);
      chk("rhold_arready", 32'(arready_o), 32'd0);
      step();
    end
    rready_i = 1;
    step();
    chk("rhold_release", 32'(rvalid_o), 32'd0);

    // B back-pressure
    bready_i = 0;
    axi_write(BASE + 32'h8, 32'h1234_5678, OK);
    for (int k = 0; k < 5; k++) begin
      chk("bhold_valid", 32'(bvalid_o), 32'd1);
      chk("bhold_readies", {30'd0, awready_o, wready_o}, 32'd0);
      step();
    end
    bready_i = 1;
    step();
    chk("bhold_readies_back", {30'd0, awready_o, wready_o}, 32'd3);
    axi_read(BASE + 32'h8, 32'h1234_5678, OK);

    // write commit and read sample on the same edge
    axi_write(BASE + 32'h14, 32'h1111_1111, OK);
    exp_wr.push_back(OK);
    exp_rd.push_back({OK, 32'h1111_1111});
    wdata_i = 32'h2222_2222; wvalid_i = 1;
    step();
    wvalid_i = 0;
    araddr_i = BASE + 32'h14; arvalid_i = 1;
    step();
    arvalid_i = 0;
    awaddr_i = BASE + 32'h14; awvalid_i = 1;
    step();
    awvalid_i = 0;
    chk("coll_bvalid", 32'(bvalid_o), 32'd1);
    chk("coll_rvalid", 32'(rvalid_o), 32'd1);
    step();
    axi_read(BASE + 32'h14, 32'h2222_2222, OK);

    // reset while the read FSM is waiting
    araddr_i = BASE + 32'h10; arvalid_i = 1;
    step();
    arvalid_i = 0;
    chk("rwait_novalid", 32'(rvalid_o), 32'd0);
    rst_i = 1;
    step();
    rst_i = 0;
    step();
    chk("rst_rd_readies", {29'd0, arready_o, awready_o, wready_o}, 32'd7);
    chk("rst_rd_valids", {30'd0, rvalid_o, bvalid_o}, 32'd0);
    repeat (4) step();
    chk("rst_rd_quiet", {30'd0, rvalid_o, bvalid_o}, 32'd0);

    // reset while only AW is held; the stale address must be forgotten
    awaddr_i = BASE + 32'h18; awvalid_i = 1;
    step();
    awvalid_i = 0;
    chk("awonly_ready", {30'd0, awready_o, wready_o}, 32'd1);
    rst_i = 1;
    step();
    rst_i = 0;
    step();
    chk("rst_aw_readies", {29'd0, arready_o, awready_o, wready_o}, 32'd7);
    chk("rst_aw_valids", {30'd0, rvalid_o, bvalid_o}, 32'd0);
    wdata_i = 32'h0000_0077; wvalid_i = 1;
    step();
    wvalid_i = 0;
    repeat (3) step();
    chk("no_stale_aw", 32'(bvalid_o), 32'd0);
    exp_wr.push_back(OK);
    awaddr_i = BASE + 32'h18; awvalid_i = 1;
    step();
    awvalid_i = 0;
    chk("aw_after_rst_b", 32'(bvalid_o), 32'd1);
    step();
    axi_read(BASE + 32'h18, 32'h0000_0077, OK);

    repeat (5) step();
    chk("r_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_wr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
